ex_lane_reg: RTL and testbench

N-lane ID→EX pipeline register for the multi-issue core, with a shared iterative divider serving lanes in order. It captures the issue bundle under the global stall/flush rules. When captured lanes carry DIV/DIVU, it asserts `stallreq_for_ex` and runs one 32-bit divide per requesting lane, lowest lane first. It writes each quotient/remainder into that lane's result slot before releasing the stall. It sits between ID and the per-lane `sub_ex` instances.

---
 rtl/ex_lane_reg_pkg.sv | 26 ++
 rtl/ex_lane_reg_if.sv | 27 ++
 rtl/ex_div_iter.sv | 89 ++++++++
 rtl/ex_lane_reg.sv | 133 +++++++++++++
 tb/tb_ex_lane_reg.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_lane_reg_pkg.sv
// Shared definitions for the ID->EX lane register: stall bus encoding,
// divider FSM states and iteration count.
package ex_lane_reg_pkg;

   localparam int   StallBus  = 6;
   localparam logic Stop      = 1'b1;
   localparam logic NoStop    = 1'b0;
   localparam int   DIV_ITERS = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ex_lane_reg_if.sv
// Issue bundle from ID and registered bundle toward the per-lane EX stages.
// Handshake: no valid/ready pair; a lane is live when its valid bit is set.
interface ex_lane_reg_if #(
   parameter int LANES   = 2,
   parameter int LANE_WD = 160
);
   logic [LANES-1:0]         in_valid;
   logic [LANES*LANE_WD-1:0] in_bus;
   logic [LANES-1:0]         in_div_req;
   logic [LANES-1:0]         in_div_signed;
   logic [LANES*32-1:0]      in_src1;
   logic [LANES*32-1:0]      in_src2;
   logic [LANES-1:0]         out_valid;
   logic [LANES*LANE_WD-1:0] out_bus;
   logic [LANES*32-1:0]      out_div_quot;
   logic [LANES*32-1:0]      out_div_rem;

   modport master (
      output in_valid, in_bus, in_div_req, in_div_signed, in_src1, in_src2,
      input  out_valid, out_bus, out_div_quot, out_div_rem
   );

   modport slave (
      input  in_valid, in_bus, in_div_req, in_div_signed, in_src1, in_src2,
      output out_valid, out_bus, out_div_quot, out_div_rem
   );
endinterface

// File: rtl/ex_div_iter.sv
// Restoring 32-bit divider datapath with iteration counter.
// EX_DIV_EARLY_OUT_EN: finish after the first step when divisor is 0 or |a| < |b|.
module ex_div_iter
   import ex_lane_reg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        div_signed,
   output logic        done,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   logic [31:0] r_q, q_q, d_q;
   logic [4:0]  cnt_q;
   logic        run_q, neg_q_q, neg_r_q;

   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] shifted;
   logic [33:0] diff;
   logic        fits, early;

   assign a_neg   = div_signed & dividend[31];
   assign b_neg   = div_signed & divisor[31];
   assign a_mag   = a_neg ? (32'd0 - dividend) : dividend;
   assign b_mag   = b_neg ? (32'd0 - divisor) : divisor;
   assign shifted = {r_q, q_q[31]};
   assign diff    = {1'b0, shifted} - {2'b00, d_q};
   assign fits    = ~diff[33];

`ifdef EX_DIV_EARLY_OUT_EN
   // q_q still holds |dividend| before the first step.
   assign early = run_q && (cnt_q == 5'd0) && ((d_q == 32'd0) || (q_q < d_q));
`else
   assign early = 1'b0;
`endif

   assign done = run_q && ((cnt_q == 5'(DIV_ITERS - 1)) || early);
   assign quot = neg_q_q ? (32'd0 - q_q) : q_q;
   assign rem  = neg_r_q ? (32'd0 - r_q) : r_q;

   wire unused_diff = diff[32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (abort) begin
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (start) begin
         r_q     <= '0;
         q_q     <= a_mag;
         d_q     <= b_mag;
         cnt_q   <= '0;
         run_q   <= 1'b1;
         // A zero divisor yields all-ones regardless of sign mode.
         neg_q_q <= (a_neg ^ b_neg) & (divisor != 32'd0);
         neg_r_q <= a_neg;
      end else if (run_q) begin
         if (early) begin
            q_q   <= (d_q == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
            r_q   <= q_q;
            run_q <= 1'b0;
         end else begin
            r_q   <= fits ? diff[31:0] : shifted[31:0];
            q_q   <= {q_q[30:0], fits};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITERS - 1)) run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ex_lane_reg.sv
// N-lane ID->EX pipeline register with a shared in-order iterative divider.
// Optional EX_DIV_EARLY_OUT_EN shortens trivial divides inside ex_div_iter.
module ex_lane_reg
   import ex_lane_reg_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int LANE_WD = 160
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [StallBus-1:0] stall,
   output logic                stallreq_for_ex,
   ex_lane_reg_if.slave        lane,
   output div_state_e          dbg_div_state
);

   localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LANES-1:0]         valid_q, pend_q, sgn_q;
   logic [LANES*LANE_WD-1:0] bus_q;
   logic [31:0]              src1_q [LANES];
   logic [31:0]              src2_q [LANES];
   logic [31:0]              quot_q [LANES];
   logic [31:0]              rem_q  [LANES];
   logic [SW-1:0]            sel_q, sel_lane;
   logic                     fresh_q;

   div_state_e state_q, state_d;
   logic       zero_regs, capture, div_abort, div_start, div_wr, div_done;
   logic [31:0] div_quot, div_rem;

   assign zero_regs = flush | ((stall[2] == Stop) && (stall[3] == NoStop));
   assign capture   = ~zero_regs && (stall[2] == NoStop);
   assign div_abort = zero_regs | capture;
   assign sel_lane  = SW'(lowest_lane(4'(pend_q)));

   wire unused_stall = ^{stall[StallBus-1:4], stall[1:0]};

   // Operands are taken from the lane registers, so the first start waits
   // one cycle after capture (fresh_q).
   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      div_wr    = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if ((pend_q != '0) && !fresh_q) begin
               div_start = 1'b1;
               state_d   = DIV_BUSY;
            end
         end
         DIV_BUSY: if (div_done) state_d = DIV_DONE;
         DIV_DONE: begin
            div_wr  = 1'b1;
            state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (div_abort) begin
         state_d   = DIV_IDLE;
         div_start = 1'b0;
         div_wr    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= DIV_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || zero_regs) begin
         valid_q <= '0;
         pend_q  <= '0;
         sgn_q   <= '0;
         bus_q   <= '0;
         sel_q   <= '0;
         fresh_q <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            src1_q[i] <= '0;
            src2_q[i] <= '0;
            quot_q[i] <= '0;
            rem_q[i]  <= '0;
         end
      end else if (capture) begin
         valid_q <= lane.in_valid;
         pend_q  <= lane.in_valid & lane.in_div_req;
         sgn_q   <= lane.in_div_signed;
         bus_q   <= lane.in_bus;
         sel_q   <= '0;
         fresh_q <= 1'b1;
         for (int i = 0; i < LANES; i++) begin
            src1_q[i] <= lane.in_src1[i*32 +: 32];
            src2_q[i] <= lane.in_src2[i*32 +: 32];
            quot_q[i] <= '0;
            rem_q[i]  <= '0;
         end
      end else begin
         fresh_q <= 1'b0;
         if (div_start) sel_q <= sel_lane;
         if (div_wr) begin
            quot_q[sel_q] <= div_quot;
            rem_q[sel_q]  <= div_rem;
            pend_q[sel_q] <= 1'b0;
         end
      end
   end

   ex_div_iter u_div (
      .clk        (clk),
      .rst        (rst),
      .start      (div_start),
      .abort      (div_abort),
      .dividend   (src1_q[sel_lane]),
      .divisor    (src2_q[sel_lane]),
      .div_signed (sgn_q[sel_lane]),
      .done       (div_done),
      .quot       (div_quot),
      .rem        (div_rem)
   );

   assign stallreq_for_ex = |pend_q;
   assign dbg_div_state   = state_q;
   assign lane.out_valid  = valid_q;
   assign lane.out_bus    = bus_q;

   for (genvar g = 0; g < LANES; g++) begin : g_slot
      assign lane.out_div_quot[g*32 +: 32] = quot_q[g];
      assign lane.out_div_rem[g*32 +: 32]  = rem_q[g];
   end

endmodule

// File: tb/tb_ex_lane_reg.sv
// Directed bench for ex_lane_reg: pass-through, divide timing/results,
// flush abort and stall bubble/hold behaviour.
module tb_ex_lane_reg;
  import ex_lane_reg_pkg::*;

  localparam int LANES   = 2;
  localparam int LANE_WD = 160;
  localparam int BW      = LANES * LANE_WD;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [StallBus-1:0] stall_force;
  wire  [StallBus-1:0] stall;
  logic                stallreq;
  div_state_e          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_q[$];

  ex_lane_reg_if #(.LANES(LANES), .LANE_WD(LANE_WD)) lif ();

  ex_lane_reg #(.LANES(LANES), .LANE_WD(LANE_WD)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .stallreq_for_ex (stallreq),
    .lane            (lif),
    .dbg_div_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // stall controller model: EX request freezes ID/EX input and output
  assign stall = stall_force | (stallreq ? 6'b001111 : 6'b000000);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    lif.in_valid      = '0;
    lif.in_bus        = '0;
    lif.in_div_req    = '0;
    lif.in_div_signed = '0;
    lif.in_src1       = '0;
    lif.in_src2       = '0;
  endtask

  task automatic issue(input logic [1:0] v, input logic [1:0] dreq, input logic [1:0] sgn,
                       input logic [63:0] s1, input logic [63:0] s2, input logic [BW-1:0] bus);
    lif.in_valid      = v;
    lif.in_div_req    = dreq;
    lif.in_div_signed = sgn;
    lif.in_src1       = s1;
    lif.in_src2       = s2;
    lif.in_bus        = bus;
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // Counts high cycles of stallreq starting at C0; snapshots quotients at C35.
  task automatic wait_div(output int cyc, output logic [63:0] q35, output logic [1:0] v0);
    cyc = -1;
    q35 = '0;
    v0  = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) v0 = lif.out_valid;
      if (!stallreq) begin
        cyc = i;
        break;
      end
      if (i == 35) q35 = lif.out_div_quot;
    end
  endtask

  initial begin : stim
    int            cyc;
    logic [63:0]   q35;
    logic [1:0]    v0;
    logic [BW-1:0] pbus, qbus, exp_bus;
    logic [31:0]   word;

    rst = 1'b1;
    flush = 1'b0;
    stall_force = '0;
    drive_idle();
    repeat (2) @(negedge clk);

    check("rst_valid", BW'(lif.out_valid), '0);
    check("rst_bus", lif.out_bus, '0);
    check("rst_stallreq", BW'(stallreq), '0);
    check("rst_state", BW'(dbg_state), BW'(DIV_IDLE));
    check("rst_quot", BW'(lif.out_div_quot), '0);
    rst = 1'b0;
    @(negedge clk);

    // pass-through, no divides
    for (int k = 0; k < 4; k++) begin
      word = (32'(k) * 32'h0101_0101) ^ 32'hA5C3_0F1E;
      lif.in_valid = 2'b11;
      lif.in_bus   = {10{word}};
      exp_q.push_back({10{word}});
      @(negedge clk);
      exp_bus = exp_q.pop_front();
      check("pass_bus", lif.out_bus, exp_bus);
      check("pass_stallreq", BW'(stallreq), '0);
    end
    drive_idle();
    @(negedge clk);

    // lane 0 DIVU 100/7, lane 1 plain instruction
    pbus = {10{32'hC0DE_0001}};
    issue(2'b11, 2'b01, 2'b00, {32'd0, 32'd100}, {32'd0, 32'd7}, pbus);
    wait_div(cyc, q35, v0);
    check("divu_valid_c0", BW'(v0), BW'(2'b11));
    check("divu_stall_cycles", BW'(cyc), BW'(35));
    check("divu_quot", BW'(lif.out_div_quot), BW'({32'd0, 32'd14}));
    check("divu_rem", BW'(lif.out_div_rem), BW'({32'd0, 32'd2}));
    check("divu_bus_held", lif.out_bus, pbus);
    @(negedge clk);

    // both lanes signed: -7/2 and 7/-2
    issue(2'b11, 2'b11, 2'b11, {32'd7, 32'hFFFF_FFF9}, {32'hFFFF_FFFE, 32'd2}, '0);
    wait_div(cyc, q35, v0);
    check("div2_stall_cycles", BW'(cyc), BW'(69));
    check("div2_lane0_first", BW'(q35), BW'({32'd0, 32'hFFFF_FFFD}));
    check("div2_quot", BW'(lif.out_div_quot), BW'({32'hFFFF_FFFD, 32'hFFFF_FFFD}));
    check("div2_rem", BW'(lif.out_div_rem), BW'({32'h0000_0001, 32'hFFFF_FFFF}));
    @(negedge clk);

    // unsigned divide by zero
    issue(2'b01, 2'b01, 2'b00, {32'd0, 32'h0000_1234}, '0, '0);
    wait_div(cyc, q35, v0);
`ifndef EX_DIV_EARLY_OUT_EN
    check("div0_stall_cycles", BW'(cyc), BW'(35));
`endif
    check("div0_quot", BW'(lif.out_div_quot), BW'({32'd0, 32'hFFFF_FFFF}));
    check("div0_rem", BW'(lif.out_div_rem), BW'({32'd0, 32'h0000_1234}));
    @(negedge clk);

    // signed overflow on lane 0, signed divide by zero on lane 1
    issue(2'b11, 2'b11, 2'b11, {32'hFFFF_FFFB, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF}, '0);
    wait_div(cyc, q35, v0);
`ifndef EX_DIV_EARLY_OUT_EN
    check("ovf_stall_cycles", BW'(cyc), BW'(69));
`endif
    check("ovf_quot", BW'(lif.out_div_quot), BW'({32'hFFFF_FFFF, 32'h8000_0000}));
    check("ovf_rem", BW'(lif.out_div_rem), BW'({32'hFFFF_FFFB, 32'h0000_0000}));
    @(negedge clk);

    // flush at BUSY iteration 10 (C12)
    issue(2'b01, 2'b01, 2'b00, {32'd0, 32'd500}, {32'd0, 32'd3}, {10{32'hF1F1_0002}});
    repeat (13) @(negedge clk);
    check("flush_pre_state", BW'(dbg_state), BW'(DIV_BUSY));
    check("flush_pre_stallreq", BW'(stallreq), BW'(1'b1));
    flush = 1'b1;
    @(negedge clk);
    check("flush_state", BW'(dbg_state), BW'(DIV_IDLE));
    check("flush_stallreq", BW'(stallreq), '0);
    check("flush_valid", BW'(lif.out_valid), '0);
    check("flush_bus", lif.out_bus, '0);
    check("flush_quot", BW'(lif.out_div_quot), '0);
    flush = 1'b0;
    @(negedge clk);

    // fresh divide after flush on lane 1
    issue(2'b10, 2'b10, 2'b00, {32'd1000, 32'd0}, {32'd10, 32'd0}, '0);
    wait_div(cyc, q35, v0);
    check("postflush_stall_cycles", BW'(cyc), BW'(35));
    check("postflush_quot", BW'(lif.out_div_quot), BW'({32'd100, 32'd0}));
    check("postflush_rem", BW'(lif.out_div_rem), BW'({32'd0, 32'd0}));
    @(negedge clk);

    // hold and bubble
    pbus = {10{32'h1357_9BDF}};
    qbus = {10{32'h2468_ACE0}};
    lif.in_valid = 2'b11;
    lif.in_bus   = pbus;
    @(negedge clk);
    check("cap_bus", lif.out_bus, pbus);
    stall_force  = 6'b001100;
    lif.in_bus   = qbus;
    @(negedge clk);
    check("hold_bus", lif.out_bus, pbus);
    check("hold_valid", BW'(lif.out_valid), BW'(2'b11));
    stall_force  = 6'b000100;
    @(negedge clk);
    check("bubble_valid", BW'(lif.out_valid), '0);
    check("bubble_bus", lif.out_bus, '0);
    stall_force  = '0;
    drive_idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
